// File: rtl/wb_mem_responder_if.sv
// Pipelined Wishbone bus bundle shared by the fetch/data masters and the
// memory responder. The slave side samples the request fields and drives
// stall plus the ack/read-data response.
interface wishbone;
   logic        stb;
   logic        stall;
   logic [31:0] adr;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] dat_w;
   logic        ack;
   logic [31:0] dat_r;

   modport slave  (input  stb, adr, we, sel, dat_w, output stall, ack, dat_r);
   modport master (output stb, adr, we, sel, dat_w, input  stall, ack, dat_r);
endinterface

// File: rtl/wb_mem_responder.sv
// Pipelined Wishbone responder backed by a word-addressed on-chip memory.
// One request per cycle, in-order acks exactly LATENCY cycles after
// acceptance, stall once MAX_OUTST requests are in flight or when
// force_stall is raised. Legal ranges: LATENCY 1..8, MAX_OUTST 1..15;
// BASE_ADDR must be aligned to the window size (4 * 2**DEPTH_W bytes).
module wb_mem_responder #(
   parameter int unsigned DEPTH_W   = 12,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int unsigned LATENCY   = 1,
   parameter int unsigned MAX_OUTST = 4,
   parameter logic [31:0] OOR_DATA  = 32'h0000_0000,
   parameter string       INIT_FILE = ""
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   force_stall,
   wishbone.slave bus
);

   localparam int unsigned WORDS     = 2 ** DEPTH_W;
   localparam logic [3:0]  OUTST_LIM = 4'(MAX_OUTST);
   localparam logic [29:0] BASE_WORD = BASE_ADDR[31:2];

   // Backing store; zero in simulation.
   logic [31:0] mem [WORDS] = '{default: '0};

   logic [3:0]         outst;
   logic [29:0]        word_off;
   logic               in_win;
   logic [DEPTH_W-1:0] idx;
   logic               accept;
   logic [31:0]        resp_dat;
   logic [LATENCY-1:0] pipe_vld;
   logic [31:0]        pipe_dat [LATENCY];
   logic               unused_adr_lsbs;

   // Byte offset bits never select anything; the word index ignores them.
   assign unused_adr_lsbs = ^bus.adr[1:0];

   // Window test on word offsets: with an aligned base this equals
   // ((adr - BASE_ADDR) >> 2) < 2**DEPTH_W in 32-bit unsigned arithmetic.
   assign word_off = bus.adr[31:2] - BASE_WORD;
   assign in_win   = (word_off >> DEPTH_W) == '0;
   assign idx      = bus.adr[DEPTH_W+1:2];

   // Stall comes only from registered state and the test hook, never from
   // stb. Reset masks the count so stall follows force_stall while in reset.
   assign bus.stall = force_stall || (!rst && (outst >= OUTST_LIM));

   // A request presented during reset is never taken, whatever stall says.
   assign accept = bus.stb && !bus.stall && !rst;

   // Response word for the request being accepted: zero for writes and idle
   // cycles so the pipeline carries zero data whenever its valid is low.
   always_comb begin
      // NOTE: default first so every path assigns resp_dat and no latch is inferred.
      resp_dat = '0;
      if (accept && !bus.we) begin
         resp_dat = in_win ? mem[idx] : OOR_DATA;
      end
   end

   // Byte-lane writes for in-window accepted writes; others are dropped.
   always_ff @(posedge clk) begin
      // NOTE: memory contents are deliberately left out of reset.
      if (accept && bus.we && in_win) begin
         for (int i = 0; i < 4; i++) begin
            if (bus.sel[i]) begin
               // NOTE: non-blocking assignment for all clocked state.
               mem[idx][8*i +: 8] <= bus.dat_w[8*i +: 8];
            end
         end
      end
   end

   // Fixed-latency response shift register; stage 0 loads at acceptance.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            pipe_dat[i] <= '0;
         end
      end else begin
         pipe_vld[0] <= accept;
         pipe_dat[0] <= resp_dat;
         for (int i = 1; i < LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_dat[i] <= pipe_dat[i-1];
         end
      end
   end

   // Outstanding count: up on acceptance, down on ack, unchanged on both.
   always_ff @(posedge clk) begin
      if (rst) begin
         outst <= '0;
      end else begin
         case ({accept, pipe_vld[LATENCY-1]})
            2'b10:   outst <= outst + 4'd1;
            2'b01:   outst <= outst - 4'd1;
            default: outst <= outst;
         endcase
      end
   end

   assign bus.ack   = pipe_vld[LATENCY-1];
   assign bus.dat_r = pipe_dat[LATENCY-1];

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench for wb_mem_responder: three instances cover LATENCY=1,
// LATENCY=3/MAX_OUTST=4 and LATENCY=4/MAX_OUTST=2. Inputs change 1 ns after
// the rising edge, outputs are sampled on the falling edge.
module tb_wb_mem_responder;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam logic [31:0] OOR1 = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        fs;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [3:0]  sel;
   int          dsel;

   wishbone w1 ();
   wishbone w3 ();
   wishbone w4 ();

   assign w1.stb = stb && (dsel == 1);
   assign w3.stb = stb && (dsel == 3);
   assign w4.stb = stb && (dsel == 4);
   assign w1.adr = adr;   assign w3.adr = adr;   assign w4.adr = adr;
   assign w1.we  = we;    assign w3.we  = we;    assign w4.we  = we;
   assign w1.sel = sel;   assign w3.sel = sel;   assign w4.sel = sel;
   assign w1.dat_w = dat_w; assign w3.dat_w = dat_w; assign w4.dat_w = dat_w;

   wb_mem_responder #(.DEPTH_W(12), .BASE_ADDR(BASE), .LATENCY(1), .MAX_OUTST(4),
                      .OOR_DATA(OOR1), .INIT_FILE(""))
      u1 (.clk(clk), .rst(rst), .force_stall(fs), .bus(w1));
   wb_mem_responder #(.DEPTH_W(12), .BASE_ADDR(BASE), .LATENCY(3), .MAX_OUTST(4),
                      .OOR_DATA(32'h0), .INIT_FILE(""))
      u3 (.clk(clk), .rst(rst), .force_stall(fs), .bus(w3));
   wb_mem_responder #(.DEPTH_W(12), .BASE_ADDR(BASE), .LATENCY(4), .MAX_OUTST(2),
                      .OOR_DATA(32'h0), .INIT_FILE(""))
      u4 (.clk(clk), .rst(rst), .force_stall(fs), .bus(w4));

   logic        stall_m;
   logic        ack_m;
   logic [31:0] dat_m;
   logic [3:0]  outst_m;

   // Outputs of the instance under test.
   always_comb begin
      stall_m = 1'b0;
      ack_m   = 1'b0;
      dat_m   = '0;
      outst_m = '0;
      case (dsel)
         1: begin stall_m = w1.stall; ack_m = w1.ack; dat_m = w1.dat_r; outst_m = u1.outst; end
         3: begin stall_m = w3.stall; ack_m = w3.ack; dat_m = w3.dat_r; outst_m = u3.outst; end
         4: begin stall_m = w4.stall; ack_m = w4.ack; dat_m = w4.dat_r; outst_m = u4.outst; end
         default: ;
      endcase
   end

   int n_tests = 0;
   int n_fail  = 0;
   int acc_cyc[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         stb = 1'b0;
         fs  = 1'b0;
      end
   endtask

   typedef struct packed {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat_w;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [15];

   function automatic logic [31:0] scan_exp(input int w);
      case (w)
         0:       return 32'h0000_0013;
         2:       return 32'h11BB_33DD;
         4:       return 32'h11BB_33DD;
         4095:    return 32'hCA00_0000;
         default: return 32'h0000_0000;
      endcase
   endfunction

   // Streams nreq requests with stb held high, checking stall/ack/dat_r each
   // cycle against an in-order queue model of the expected responder.
   task automatic run_stream(input string tag, input int lat, input int mo, input logic we_i,
                             input int nreq, input logic [31:0] dbase,
                             input int fs_from, input int fs_to);
      int          n_acc, dut_acks, m_out, max_o, c;
      int          pend_c[$];
      int          pend_i[$];
      logic        exp_stall, exp_ack, acc;
      logic [31:0] exp_dat;
      n_acc = 0; dut_acks = 0; m_out = 0; max_o = 0; c = 0;
      acc_cyc.delete();
      while (c < 80 && (n_acc < nreq || pend_c.size() > 0)) begin
         @(posedge clk); #1;
         stb   = (n_acc < nreq);
         we    = we_i;
         sel   = 4'hF;
         adr   = BASE + 32'(4 * n_acc);
         dat_w = dbase + 32'(n_acc);
         fs    = (c >= fs_from) && (c <= fs_to);
         @(negedge clk);
         exp_stall = fs || (m_out >= mo);
         exp_ack   = (pend_c.size() > 0) && (pend_c[0] + lat == c);
         exp_dat   = '0;
         if (exp_ack && !we_i) exp_dat = dbase + 32'(pend_i[0]);
         check($sformatf("%s_stall_c%0d", tag, c), stall_m, exp_stall);
         check($sformatf("%s_ack_c%0d", tag, c), ack_m, exp_ack);
         check($sformatf("%s_dat_c%0d", tag, c), dat_m, exp_dat);
         if (ack_m) dut_acks++;
         if (int'(outst_m) > max_o) max_o = int'(outst_m);
         acc = stb && !exp_stall;
         if (acc) begin
            pend_c.push_back(c);
            pend_i.push_back(n_acc);
            acc_cyc.push_back(c);
            n_acc++;
         end
         if (exp_ack) begin
            void'(pend_c.pop_front());
            void'(pend_i.pop_front());
         end
         m_out = m_out + int'(acc) - int'(exp_ack);
         c++;
      end
      @(posedge clk); #1;
      stb = 1'b0;
      fs  = 1'b0;
      @(negedge clk);
      check($sformatf("%s_tail_ack", tag), ack_m, 1'b0);
      check($sformatf("%s_ack_count", tag), dut_acks, nreq);
      check($sformatf("%s_outst_le_max", tag), max_o <= mo, 1'b1);
   endtask

   task automatic check_acc(input string tag, input int exp_c[8], input int n);
      check($sformatf("%s_n_accepted", tag), acc_cyc.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < acc_cyc.size()) check($sformatf("%s_accept%0d_cycle", tag, i), acc_cyc[i], exp_c[i]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset state ----------------
      rst = 1'b1; fs = 1'b0; dsel = 1; stb = 1'b1; we = 1'b0;
      adr = BASE; dat_w = '0; sel = 4'hF;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_stall_u1", w1.stall, 1'b0);
      check("rst_stall_u3", w3.stall, 1'b0);
      check("rst_stall_u4", w4.stall, 1'b0);
      check("rst_ack_u1", w1.ack, 1'b0);
      check("rst_ack_u3", w3.ack, 1'b0);
      check("rst_ack_u4", w4.ack, 1'b0);
      check("rst_dat_u1", w1.dat_r, 32'h0);
      @(posedge clk); #1;
      fs = 1'b1;
      @(negedge clk);
      check("rst_force_stall_u1", w1.stall, 1'b1);
      check("rst_force_stall_u4", w4.stall, 1'b1);
      @(posedge clk); #1;
      rst = 1'b0; fs = 1'b0; stb = 1'b0;
      @(negedge clk);
      check("post_rst_ack0", ack_m, 1'b0);
      check("post_rst_outst", outst_m, 4'd0);
      @(posedge clk);
      @(negedge clk);
      check("post_rst_ack1", ack_m, 1'b0);

      // ---------------- LATENCY=1 single-request vectors ----------------
      vecs[0]  = '{1'b1, 32'h8000_0000, 4'hF, 32'h0000_0013, 32'h0};
      vecs[1]  = '{1'b0, 32'h8000_0000, 4'hF, 32'h0,         32'h0000_0013};
      vecs[2]  = '{1'b1, 32'h8000_0010, 4'hF, 32'h1122_3344, 32'h0};
      vecs[3]  = '{1'b1, 32'h8000_0010, 4'h5, 32'hAABB_CCDD, 32'h0};
      vecs[4]  = '{1'b0, 32'h8000_0010, 4'hF, 32'h0,         32'h11BB_33DD};
      vecs[5]  = '{1'b0, 32'h7FFF_FFFC, 4'hF, 32'h0,         OOR1};
      vecs[6]  = '{1'b0, 32'h8000_4000, 4'hF, 32'h0,         OOR1};
      vecs[7]  = '{1'b1, 32'h0000_0000, 4'hF, 32'hFFFF_FFFF, 32'h0};
      vecs[8]  = '{1'b0, 32'h8000_0000, 4'hF, 32'h0,         32'h0000_0013};
      vecs[9]  = '{1'b1, 32'h8000_3FFC, 4'h8, 32'hCAFE_F00D, 32'h0};
      vecs[10] = '{1'b0, 32'h8000_3FFC, 4'hF, 32'h0,         32'hCA00_0000};
      vecs[11] = '{1'b1, 32'h7FFF_FFFC, 4'hF, 32'hFFFF_FFFF, 32'h0};
      vecs[12] = '{1'b0, 32'h8000_3FFC, 4'hF, 32'h0,         32'hCA00_0000};
      vecs[13] = '{1'b0, 32'h8000_4010, 4'hF, 32'h0,         OOR1};
      vecs[14] = '{1'b0, 32'h8000_0013, 4'hF, 32'h0,         32'h11BB_33DD};
      dsel = 1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         stb = 1'b1; we = vecs[i].we; adr = vecs[i].adr; sel = vecs[i].sel; dat_w = vecs[i].dat_w;
         @(negedge clk);
         check($sformatf("vec%0d_stall", i), stall_m, 1'b0);
         check($sformatf("vec%0d_pre_ack", i), ack_m, 1'b0);
         check($sformatf("vec%0d_pre_dat", i), dat_m, 32'h0);
         @(posedge clk); #1;
         stb = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_ack", i), ack_m, 1'b1);
         check($sformatf("vec%0d_dat", i), dat_m, vecs[i].exp);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d_post_ack", i), ack_m, 1'b0);
         check($sformatf("vec%0d_post_dat", i), dat_m, 32'h0);
      end

      // ---------------- back-to-back write, byte write, read ----------------
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         stb = (c < 3); adr = 32'h8000_0008;
         we  = (c < 2);
         sel = (c == 1) ? 4'h5 : 4'hF;
         dat_w = (c == 1) ? 32'hAABB_CCDD : 32'h1122_3344;
         @(negedge clk);
         check($sformatf("b2b_ack_c%0d", c), ack_m, (c >= 1) && (c <= 3));
         check($sformatf("b2b_dat_c%0d", c), dat_m, (c == 3) ? 32'h11BB_33DD : 32'h0);
      end

      // ---------------- full-window pipelined scan ----------------
      for (int c = 0; c <= 4096; c++) begin
         @(posedge clk); #1;
         stb = (c < 4096); we = 1'b0; adr = BASE + 32'(4 * c);
         @(negedge clk);
         if (c >= 1) begin
            check($sformatf("scan_ack_w%0d", c - 1), ack_m, 1'b1);
            check($sformatf("scan_dat_w%0d", c - 1), dat_m, scan_exp(c - 1));
         end
      end
      idle(2);

      // ---------------- LATENCY=3 bursts and force_stall ----------------
      dsel = 3;
      run_stream("l3_wr", 3, 4, 1'b1, 8, 32'h0000_0300, -1, -1);
      check_acc("l3_wr", '{0, 1, 2, 3, 4, 5, 6, 7}, 8);
      idle(2);
      run_stream("l3_rd", 3, 4, 1'b0, 8, 32'h0000_0300, -1, -1);
      check_acc("l3_rd", '{0, 1, 2, 3, 4, 5, 6, 7}, 8);
      idle(2);
      run_stream("l3_fs", 3, 4, 1'b0, 8, 32'h0000_0300, 2, 4);
      check_acc("l3_fs", '{0, 1, 5, 6, 7, 8, 9, 10}, 8);
      idle(2);

      // ---------------- LATENCY=4, MAX_OUTST=2 limit ----------------
      dsel = 4;
      run_stream("l4_wr", 4, 2, 1'b1, 6, 32'h0000_0400, -1, -1);
      check_acc("l4_wr", '{0, 1, 5, 6, 10, 11, 0, 0}, 6);
      idle(2);
      run_stream("l4_rd", 4, 2, 1'b0, 6, 32'h0000_0400, -1, -1);
      check_acc("l4_rd", '{0, 1, 5, 6, 10, 11, 0, 0}, 6);
      idle(2);

      // ---------------- reset with requests in flight (LATENCY=3) ----------------
      dsel = 3;
      for (int c = 0; c < 13; c++) begin
         @(posedge clk); #1;
         stb = (c == 0) || (c == 1) || (c == 3) || (c == 7);
         we  = 1'b0;
         case (c)
            0:       adr = BASE;
            1:       adr = BASE + 32'd4;
            3:       adr = BASE + 32'd8;
            default: adr = BASE + 32'd20;
         endcase
         rst = (c == 2) || (c == 3);
         @(negedge clk);
         check($sformatf("rstfl_ack_c%0d", c), ack_m, c == 10);
         check($sformatf("rstfl_dat_c%0d", c), dat_m, (c == 10) ? 32'h0000_0305 : 32'h0);
         if (c == 3) check("rstfl_stall_in_rst", stall_m, 1'b0);
         if (c == 4) check("rstfl_outst_cleared", outst_m, 4'd0);
      end
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
